// File: rtl/addsub_share_pkg.sv
// Shared constants for the add/subtract sharing controller: FSM encodings and requester IDs.
package addsub_share_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic RID0 = 1'b0;
    localparam logic RID1 = 1'b1;

endpackage

// File: rtl/addsub_share_ctrl_rr_pick2.sv
// Combinational two-way round-robin pick: one-hot grant, ties go to the requester not served last.
module rr_pick2
    import addsub_share_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_id,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (valid == 2'b11) begin
            grant = (last_id == RID0) ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Shares one fixed-latency registered adder between two requesters; one operation in flight,
// response held until the consumer accepts it.
module addsub_share_ctrl
    import addsub_share_pkg::*;
#(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [N-1:0] r0_a,
    input  logic [N-1:0] r0_b,
    input  logic         r0_sub,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [N-1:0] r1_a,
    input  logic [N-1:0] r1_b,
    input  logic         r1_sub,
    output logic [N-1:0] adu_a,
    output logic [N-1:0] adu_b,
    output logic         adu_sub,
    input  logic [N-1:0] adu_sum,
    input  logic         adu_cout,
    input  logic         adu_ovf,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_ovf
);

    localparam int CW = $clog2(LAT) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic          sub_q, sub_d, id_q, id_d, last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [N-1:0]  rsp_sum_q, rsp_sum_d;
    logic          rsp_cout_q, rsp_cout_d, rsp_ovf_q, rsp_ovf_d;
    logic [1:0]    grant;
    logic          busy;

    rr_pick2 u_pick (
        .valid   ({r1_valid, r0_valid}),
        .last_id (last_q),
        .grant   (grant)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        id_d        = id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        r0_ready    = 1'b0;
        r1_ready    = 1'b0;
        case (state_q)
            S_IDLE: begin
                r0_ready = grant[0];
                r1_ready = grant[1];
                if (r0_valid && grant[0]) begin
                    a_d     = r0_a;
                    b_d     = r0_b;
                    sub_d   = r0_sub;
                    id_d    = RID0;
                    last_d  = RID0;
                    state_d = S_ISSUE;
                end else if (r1_valid && grant[1]) begin
                    a_d     = r1_a;
                    b_d     = r1_b;
                    sub_d   = r1_sub;
                    id_d    = RID1;
                    last_d  = RID1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter reaches zero exactly when the adder output reflects the issued operands.
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_sum_d   = adu_sum;
                    rsp_cout_d  = adu_cout;
                    rsp_ovf_d   = adu_ovf;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
        adu_a   = busy ? a_q : '0;
        adu_b   = busy ? b_q : '0;
        adu_sub = busy ? sub_q : 1'b0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            id_q        <= RID0;
            last_q      <= RID1;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            id_q        <= id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Bench for addsub_share_ctrl: LAT=1 and LAT=3 instances, each with a behavioural adder and a
// response scoreboard checked by an independent monitor.
module tb_addsub_share_ctrl;

    localparam int N = 4;

    typedef struct packed {
        logic         id;
        logic         cout;
        logic         ovf;
        logic [N-1:0] sum;
    } rsp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_miss = 0;
    rsp_t q1[$];
    rsp_t q3[$];

    // LAT=1 instance signals
    logic r0_valid = 0, r0_ready, r0_sub = 0, r1_valid = 0, r1_ready, r1_sub = 0;
    logic [N-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [N-1:0] adu_a, adu_b, adu_sum, rsp_sum;
    logic adu_sub, adu_cout, adu_ovf, rsp_valid, rsp_ready = 1, rsp_id, rsp_cout, rsp_ovf;

    // LAT=3 instance signals
    logic s_r0_valid = 0, s_r0_ready, s_r0_sub = 0, s_r1_valid = 0, s_r1_ready, s_r1_sub = 0;
    logic [N-1:0] s_r0_a = '0, s_r0_b = '0, s_r1_a = '0, s_r1_b = '0;
    logic [N-1:0] s_adu_a, s_adu_b, s_adu_sum, s_rsp_sum;
    logic s_adu_sub, s_adu_cout, s_adu_ovf, s_rsp_valid, s_rsp_ready = 1, s_rsp_id, s_rsp_cout, s_rsp_ovf;

    addsub_share_ctrl #(.N(N), .LAT(1)) u1 (
        .CLOCK_50(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
        .adu_a(adu_a), .adu_b(adu_b), .adu_sub(adu_sub),
        .adu_sum(adu_sum), .adu_cout(adu_cout), .adu_ovf(adu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    addsub_share_ctrl #(.N(N), .LAT(3)) u3 (
        .CLOCK_50(clk), .resetn(resetn),
        .r0_valid(s_r0_valid), .r0_ready(s_r0_ready), .r0_a(s_r0_a), .r0_b(s_r0_b), .r0_sub(s_r0_sub),
        .r1_valid(s_r1_valid), .r1_ready(s_r1_ready), .r1_a(s_r1_a), .r1_b(s_r1_b), .r1_sub(s_r1_sub),
        .adu_a(s_adu_a), .adu_b(s_adu_b), .adu_sub(s_adu_sub),
        .adu_sum(s_adu_sum), .adu_cout(s_adu_cout), .adu_ovf(s_adu_ovf),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
        .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout), .rsp_ovf(s_rsp_ovf)
    );

    // Behavioural shared adder: {ovf, cout, sum}
    function automatic logic [N+1:0] add_fn(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        logic [N-1:0] bb;
        logic [N:0]   t;
        logic         ovf;
        bb  = sub ? ~b : b;
        t   = (N+1)'(a) + (N+1)'(bb) + (N+1)'(sub);
        ovf = (a[N-1] == bb[N-1]) && (t[N-1] != a[N-1]);
        return {ovf, t[N], t[N-1:0]};
    endfunction

    logic [N+1:0] p1 = '0;
    logic [N+1:0] p3_0 = '0, p3_1 = '0, p3_2 = '0;
    always @(posedge clk) begin
        p1   <= add_fn(adu_a, adu_b, adu_sub);
        p3_0 <= add_fn(s_adu_a, s_adu_b, s_adu_sub);
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign {adu_ovf, adu_cout, adu_sum}       = p1;
    assign {s_adu_ovf, s_adu_cout, s_adu_sum} = p3_2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard monitors
    initial forever begin
        @(negedge clk);
        if (rsp_valid && rsp_ready) begin
            if (q1.size() == 0) timeout_fail("rsp1_unexpected");
            else chk("rsp1", {rsp_id, rsp_cout, rsp_ovf, rsp_sum}, q1.pop_front());
        end
    end

    initial forever begin
        @(negedge clk);
        if (s_rsp_valid && s_rsp_ready) begin
            if (q3.size() == 0) timeout_fail("rsp3_unexpected");
            else chk("rsp3", {s_rsp_id, s_rsp_cout, s_rsp_ovf, s_rsp_sum}, q3.pop_front());
        end
    end

    task automatic wait_rdy(input bit which, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (which ? r1_ready : r0_ready) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) timeout_fail("grant_wait");
    endtask

    task automatic wait_rsp(input int hs, input int lat_exp);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("rsp_latency", cyc - hs, lat_exp);
                return;
            end
        end
        timeout_fail("rsp_wait");
    endtask

    task automatic drain1();
        for (int i = 0; i < 40; i++) begin
            if (q1.size() == 0) return;
            @(negedge clk);
        end
        timeout_fail("drain");
    endtask

    task automatic single_op(input bit which, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic sub, input rsp_t exp);
        int hs;
        @(posedge clk); #1;
        if (which) begin r1_valid = 1; r1_a = a; r1_b = b; r1_sub = sub; end
        else       begin r0_valid = 1; r0_a = a; r0_b = b; r0_sub = sub; end
        wait_rdy(which, hs);
        if (hs >= 0) begin
            chk("other_ready", which ? r0_ready : r1_ready, 0);
            q1.push_back(exp);
            @(posedge clk); #1;
            // Scramble operands after handshake; must not affect the result
            if (which) begin r1_valid = 0; r1_a = '0; r1_b = '0; r1_sub = ~sub; end
            else       begin r0_valid = 0; r0_a = '0; r0_b = '0; r0_sub = ~sub; end
            @(negedge clk);
            chk("ready_one_cycle", which ? r1_ready : r0_ready, 0);
            wait_rsp(hs, 3);
        end
        drain1();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs, prev, acc;
        bit e;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {r0_ready, r1_ready, adu_a, adu_b, adu_sub, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 0);
        @(posedge clk); #1 resetn = 1;
        @(negedge clk);
        chk("idle_outs", {r0_ready, r1_ready, adu_a, adu_b, adu_sub, rsp_valid, rsp_sum}, 0);

        // Single operations
        single_op(0, 4'h5, 4'h3, 0, '{id:0, cout:0, ovf:1, sum:4'h8});
        single_op(1, 4'h3, 4'h5, 1, '{id:1, cout:0, ovf:0, sum:4'hE});
        single_op(1, 4'h7, 4'h7, 1, '{id:1, cout:1, ovf:0, sum:4'h0});

        // Both requesters valid continuously
        @(posedge clk); #1;
        r0_valid = 1; r0_a = 4'h1; r0_b = 4'h2; r0_sub = 0;
        r1_valid = 1; r1_a = 4'h9; r1_b = 4'h4; r1_sub = 1;
        prev = -1; e = 0;
        for (int k = 0; k < 4; k++) begin
            hs = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                chk("both_ready", r0_ready & r1_ready, 0);
                if (r0_ready | r1_ready) begin hs = cyc; break; end
            end
            if (hs < 0) begin timeout_fail("rr_grant"); break; end
            chk("rr_order", r1_ready, e);
            if (prev >= 0) chk("grant_spacing", hs - prev, 4);
            if (r1_ready) q1.push_back('{id:1, cout:1, ovf:1, sum:4'h5});
            else          q1.push_back('{id:0, cout:0, ovf:0, sum:4'h3});
            prev = hs;
            e = ~e;
        end
        @(posedge clk); #1 r0_valid = 0; r1_valid = 0;
        drain1();

        // Backpressure: response held while rsp_ready is low
        @(posedge clk); #1;
        rsp_ready = 0;
        r0_valid = 1; r0_a = 4'h2; r0_b = 4'h6; r0_sub = 0;
        r1_valid = 1; r1_a = 4'h4; r1_b = 4'h4; r1_sub = 1;
        wait_rdy(0, hs);
        if (hs >= 0) begin
            chk("bp_r1_not_ready", r1_ready, 0);
            q1.push_back('{id:0, cout:0, ovf:1, sum:4'h8});
            @(posedge clk); #1 r0_valid = 0;
            wait_rsp(hs, 3);
            repeat (5) begin
                @(negedge clk);
                chk("bp_hold", {rsp_valid, rsp_id, rsp_cout, rsp_ovf, rsp_sum}, {1'b1, 1'b0, 1'b0, 1'b1, 4'h8});
                chk("bp_no_ready", {r0_ready, r1_ready}, 0);
            end
            @(posedge clk); #1 rsp_ready = 1;
            @(negedge clk);
            acc = cyc;
            chk("bp_accept_cycle_ready", r1_ready, 0);
            @(negedge clk);
            chk("bp_grant_after_accept", {r1_ready, 32'(cyc - acc)}, {1'b1, 32'd1});
            if (r1_ready) q1.push_back('{id:1, cout:1, ovf:0, sum:4'h0});
            hs = cyc;
            @(posedge clk); #1 r1_valid = 0;
            wait_rsp(hs, 3);
        end
        drain1();

        // Reset during WAIT abandons the operation
        @(posedge clk); #1;
        r1_valid = 1; r1_a = 4'h1; r1_b = 4'h1; r1_sub = 0;
        wait_rdy(1, hs);
        @(posedge clk); #1 r1_valid = 0;
        @(negedge clk);
        chk("issue_adu", {adu_a, adu_b, adu_sub}, {4'h1, 4'h1, 1'b0});
        @(posedge clk); #1 resetn = 0;
        @(negedge clk);
        chk("wait_adu", {adu_a, adu_b}, {4'h1, 4'h1});
        @(posedge clk); #1 resetn = 1;
        repeat (3) begin
            @(negedge clk);
            chk("abandon_outs", {rsp_valid, adu_a, adu_b, adu_sub}, 0);
        end
        @(posedge clk); #1;
        r0_valid = 1; r0_a = 4'h6; r0_b = 4'h1; r0_sub = 1;
        r1_valid = 1; r1_a = 4'h2; r1_b = 4'h3; r1_sub = 0;
        wait_rdy(0, hs);
        if (hs >= 0) begin
            chk("post_reset_pick_r0", r1_ready, 0);
            q1.push_back('{id:0, cout:1, ovf:0, sum:4'h5});
            @(posedge clk); #1 r0_valid = 0;
            wait_rsp(hs, 3);
            wait_rdy(1, hs);
            if (hs >= 0) begin
                q1.push_back('{id:1, cout:0, ovf:0, sum:4'h5});
                @(posedge clk); #1 r1_valid = 0;
                wait_rsp(hs, 3);
            end
        end
        r0_valid = 0; r1_valid = 0;
        drain1();

        // LAT=3 instance
        @(posedge clk); #1;
        s_r0_valid = 1; s_r0_a = 4'hF; s_r0_b = 4'h1; s_r0_sub = 0;
        hs = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_r0_ready) begin hs = cyc; break; end
        end
        if (hs < 0) timeout_fail("lat3_grant");
        else begin
            chk("lat3_r1_ready", s_r1_ready, 0);
            q3.push_back('{id:0, cout:1, ovf:0, sum:4'h0});
            @(posedge clk); #1 s_r0_valid = 0; s_r0_a = 4'h0; s_r0_b = 4'h7;
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                chk("lat3_adu_stable", {s_rsp_valid, s_adu_a, s_adu_b, s_adu_sub}, {1'b0, 4'hF, 4'h1, 1'b0});
            end
            @(negedge clk);
            chk("lat3_latency", {s_rsp_valid, 32'(cyc - hs)}, {1'b1, 32'd5});
            chk("lat3_adu_cleared", {s_adu_a, s_adu_b}, 0);
        end
        repeat (3) @(negedge clk);

        chk("q1_empty", q1.size(), 0);
        chk("q3_empty", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
